// File: rtl/dram_cache_pkg.sv
// Shared types and default sizing for the DRAM-cache read path.
// Used by the read reorder buffer and the blocks that feed it.
package dram_cache_pkg;

    localparam int ROB_TID_WIDTH  = 6;
    localparam int ROB_DATA_WIDTH = 64;
    localparam int ROB_DEPTH      = 1 << ROB_TID_WIDTH;
    localparam int ROB_AFULL_THR  = 62;

    typedef logic [ROB_TID_WIDTH-1:0] tid_t;

    typedef struct packed {
        tid_t                      tid;
        logic [ROB_DATA_WIDTH-1:0] data;
    } rob_wdata_t;

endpackage

// File: rtl/rob_out_reg.sv
// Single-entry valid/ready output register for the read reorder buffer.
// Reports when it takes a new entry and when the consumer accepts one.
module rob_out_reg
    import dram_cache_pkg::*;
#(
    parameter int TID_WIDTH  = ROB_TID_WIDTH,
    parameter int DATA_WIDTH = ROB_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_avail,
    input  logic [TID_WIDTH-1:0]  i_rid,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_ready,
    output logic                  o_load,
    output logic                  o_consume,
    output logic                  o_valid,
    output logic [TID_WIDTH-1:0]  o_rid,
    output logic [DATA_WIDTH-1:0] o_data
);

    logic                  r_valid;
    logic [TID_WIDTH-1:0]  r_rid;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  w_consume;
    logic                  w_load;

    assign w_consume = r_valid & i_ready;
    assign w_load    = i_avail & (~r_valid | w_consume);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_rid   <= '0;
            r_data  <= '0;
        end else if (w_load) begin
            r_valid <= 1'b1;
            r_rid   <= i_rid;
            r_data  <= i_data;
        end else if (w_consume) begin
            r_valid <= 1'b0;
        end
    end

    assign o_load    = w_load;
    assign o_consume = w_consume;
    assign o_valid   = r_valid;
    assign o_rid     = r_rid;
    assign o_data    = r_data;

endmodule

// File: rtl/read_reorder_buffer.sv
// Collects TID-tagged read responses from the hit and miss paths in any order
// and releases them to the R channel strictly in ascending TID order.
module read_reorder_buffer
    import dram_cache_pkg::*;
#(
    parameter int TID_WIDTH  = ROB_TID_WIDTH,
    parameter int DATA_WIDTH = ROB_DATA_WIDTH,
    parameter int AFULL_THR  = ROB_AFULL_THR
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            write_en_hit_i,
    input  logic [TID_WIDTH+DATA_WIDTH-1:0] wdata_hit_i,
    output logic                            full_hit_o,
    input  logic                            write_en_miss_i,
    input  logic [TID_WIDTH+DATA_WIDTH-1:0] wdata_miss_i,
    output logic                            full_miss_o,
    output logic                            valid_o,
    input  logic                            ready_i,
    output logic [TID_WIDTH-1:0]            rid_o,
    output logic [DATA_WIDTH-1:0]           rdata_o,
    output logic                            err_o
);

    localparam int DEPTH = 1 << TID_WIDTH;
    localparam int CW    = TID_WIDTH + 1;

    logic [DEPTH-1:0]      r_slotValid;
    logic [DATA_WIDTH-1:0] r_slotData [DEPTH];
    logic [TID_WIDTH-1:0]  r_head;
    logic [CW-1:0]         r_count;
    logic                  r_full;
    logic                  r_err;

    logic [TID_WIDTH-1:0]  w_hitTid;
    logic [DATA_WIDTH-1:0] w_hitData;
    logic [TID_WIDTH-1:0]  w_missTid;
    logic [DATA_WIDTH-1:0] w_missData;
    logic                  w_hitAccept;
    logic                  w_missAccept;
    logic                  w_errSet;
    logic                  w_load;
    logic                  w_consume;
    logic [CW-1:0]         w_countNext;

    assign w_hitTid   = wdata_hit_i[TID_WIDTH+DATA_WIDTH-1 -: TID_WIDTH];
    assign w_hitData  = wdata_hit_i[DATA_WIDTH-1:0];
    assign w_missTid  = wdata_miss_i[TID_WIDTH+DATA_WIDTH-1 -: TID_WIDTH];
    assign w_missData = wdata_miss_i[DATA_WIDTH-1:0];

    // A slot being drained this cycle is still valid, so a write to it is a collision.
    assign w_hitAccept  = write_en_hit_i & ~r_slotValid[w_hitTid];
    assign w_missAccept = write_en_miss_i & ~r_slotValid[w_missTid]
                        & ~(write_en_hit_i & (w_hitTid == w_missTid));
    assign w_errSet     = (write_en_hit_i & ~w_hitAccept) | (write_en_miss_i & ~w_missAccept);

    assign w_countNext = r_count + CW'(w_hitAccept) + CW'(w_missAccept) - CW'(w_consume);

    rob_out_reg #(
        .TID_WIDTH  (TID_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_outReg (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_avail   (r_slotValid[r_head]),
        .i_rid     (r_head),
        .i_data    (r_slotData[r_head]),
        .i_ready   (ready_i),
        .o_load    (w_load),
        .o_consume (w_consume),
        .o_valid   (valid_o),
        .o_rid     (rid_o),
        .o_data    (rdata_o)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_slotValid <= '0;
            r_head      <= '0;
            r_count     <= '0;
            r_full      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            if (w_load) begin
                r_slotValid[r_head] <= 1'b0;
                r_head              <= r_head + 1'b1;
            end
            if (w_hitAccept) begin
                r_slotValid[w_hitTid] <= 1'b1;
            end
            if (w_missAccept) begin
                r_slotValid[w_missTid] <= 1'b1;
            end
            r_count <= w_countNext;
            r_full  <= (w_countNext >= CW'(AFULL_THR));
            if (w_errSet) begin
                r_err <= 1'b1;
            end
        end
    end

    // Slot payloads need no reset; the valid bits gate every use.
    always_ff @(posedge clk) begin
        if (w_hitAccept) begin
            r_slotData[w_hitTid] <= w_hitData;
        end
        if (w_missAccept) begin
            r_slotData[w_missTid] <= w_missData;
        end
    end

    assign full_hit_o  = r_full;
    assign full_miss_o = r_full;
    assign err_o       = r_err;

endmodule

// File: tb/tb_read_reorder_buffer.sv
// Directed self-checking bench for read_reorder_buffer.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_read_reorder_buffer;
    import dram_cache_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              write_en_hit_i;
    logic [69:0]       wdata_hit_i;
    logic              full_hit_o;
    logic              write_en_miss_i;
    logic [69:0]       wdata_miss_i;
    logic              full_miss_o;
    logic              valid_o;
    logic              ready_i;
    logic [5:0]        rid_o;
    logic [63:0]       rdata_o;
    logic              err_o;

    int passCount  = 0;
    int checkCount = 0;

    always #5 clk = ~clk;

    read_reorder_buffer dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .write_en_hit_i  (write_en_hit_i),
        .wdata_hit_i     (wdata_hit_i),
        .full_hit_o      (full_hit_o),
        .write_en_miss_i (write_en_miss_i),
        .wdata_miss_i    (wdata_miss_i),
        .full_miss_o     (full_miss_o),
        .valid_o         (valid_o),
        .ready_i         (ready_i),
        .rid_o           (rid_o),
        .rdata_o         (rdata_o),
        .err_o           (err_o)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic hitEn, input tid_t hitTid, input logic [63:0] hitData,
                                 input logic missEn, input tid_t missTid, input logic [63:0] missData);
        rob_wdata_t hitWord;
        rob_wdata_t missWord;
        hitWord.tid     = hitTid;
        hitWord.data    = hitData;
        missWord.tid    = missTid;
        missWord.data   = missData;
        write_en_hit_i  = hitEn;
        wdata_hit_i     = hitWord;
        write_en_miss_i = missEn;
        wdata_miss_i    = missWord;
    endtask

    task automatic idle();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic resetDut();
        rst_n   = 1'b0;
        ready_i = 1'b0;
        idle();
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic expectResp(input string tag, input tid_t rid, input logic [63:0] data);
        checkOutput({tag, " valid"}, 64'(valid_o), 64'd1);
        checkOutput({tag, " rid"}, 64'(rid_o), 64'(rid));
        checkOutput({tag, " data"}, rdata_o, data);
    endtask

    initial begin
        // Reset state
        resetDut();
        checkOutput("rst valid", 64'(valid_o), 64'd0);
        checkOutput("rst rid", 64'(rid_o), 64'd0);
        checkOutput("rst rdata", rdata_o, 64'd0);
        checkOutput("rst err", 64'(err_o), 64'd0);
        checkOutput("rst fullHit", 64'(full_hit_o), 64'd0);
        checkOutput("rst fullMiss", 64'(full_miss_o), 64'd0);

        // In-order hit writes, two-cycle latency then one per cycle
        ready_i = 1'b1;
        applyStimulus(1'b1, 6'd0, 64'hA0, 1'b0, '0, '0);
        step();
        applyStimulus(1'b1, 6'd1, 64'hA1, 1'b0, '0, '0);
        checkOutput("inorder c1 valid", 64'(valid_o), 64'd0);
        step();
        applyStimulus(1'b1, 6'd2, 64'hA2, 1'b0, '0, '0);
        expectResp("inorder c2", 6'd0, 64'hA0);
        step();
        idle();
        expectResp("inorder c3", 6'd1, 64'hA1);
        step();
        expectResp("inorder c4", 6'd2, 64'hA2);
        step();
        checkOutput("inorder c5 valid", 64'(valid_o), 64'd0);
        checkOutput("inorder err", 64'(err_o), 64'd0);

        // Out-of-order arrival: head-of-line blocking until TID 0 shows up
        resetDut();
        ready_i = 1'b1;
        applyStimulus(1'b0, '0, '0, 1'b1, 6'd1, 64'hB1);
        step();
        idle();
        checkOutput("ooo c1 valid", 64'(valid_o), 64'd0);
        step();
        checkOutput("ooo c2 valid", 64'(valid_o), 64'd0);
        step();
        applyStimulus(1'b1, 6'd0, 64'hB0, 1'b0, '0, '0);
        checkOutput("ooo c3 valid", 64'(valid_o), 64'd0);
        step();
        idle();
        checkOutput("ooo c4 valid", 64'(valid_o), 64'd0);
        step();
        expectResp("ooo c5", 6'd0, 64'hB0);
        step();
        expectResp("ooo c6", 6'd1, 64'hB1);
        step();
        checkOutput("ooo c7 valid", 64'(valid_o), 64'd0);

        // Backpressure holds the presented response stable
        resetDut();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, tid_t'(i), 64'h30 + 64'(i), 1'b0, '0, '0);
            step();
        end
        idle();
        for (int i = 0; i < 10; i++) begin
            expectResp($sformatf("bp hold%0d", i), 6'd0, 64'h30);
            step();
        end
        ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            expectResp($sformatf("bp drain%0d", i), tid_t'(i), 64'h30 + 64'(i));
            step();
        end
        checkOutput("bp empty valid", 64'(valid_o), 64'd0);

        // Almost-full threshold, drain, then TID wrap 63 -> 0 -> 1
        resetDut();
        for (int i = 0; i < 63; i++) begin
            applyStimulus(1'b1, tid_t'(i), 64'h100 + 64'(i), 1'b0, '0, '0);
            if (i == 61) begin
                checkOutput("afull at 61 hit", 64'(full_hit_o), 64'd0);
            end
            if (i == 62) begin
                checkOutput("afull at 62 hit", 64'(full_hit_o), 64'd1);
                checkOutput("afull at 62 miss", 64'(full_miss_o), 64'd1);
            end
            step();
        end
        idle();
        checkOutput("afull held", 64'(full_hit_o), 64'd1);
        ready_i = 1'b1;
        for (int i = 0; i < 63; i++) begin
            checkOutput($sformatf("drain rid%0d", i), 64'(rid_o), 64'(i));
            if (i == 40) begin
                checkOutput("drain data40", rdata_o, 64'h128);
            end
            step();
        end
        checkOutput("drained valid", 64'(valid_o), 64'd0);
        checkOutput("drained fullHit", 64'(full_hit_o), 64'd0);
        checkOutput("drained fullMiss", 64'(full_miss_o), 64'd0);
        applyStimulus(1'b1, 6'd63, 64'hE3, 1'b0, '0, '0);
        step();
        applyStimulus(1'b0, '0, '0, 1'b1, 6'd0, 64'hE0);
        step();
        applyStimulus(1'b1, 6'd1, 64'hE1, 1'b0, '0, '0);
        expectResp("wrap 63", 6'd63, 64'hE3);
        step();
        idle();
        expectResp("wrap 0", 6'd0, 64'hE0);
        step();
        expectResp("wrap 1", 6'd1, 64'hE1);
        step();
        checkOutput("wrap end valid", 64'(valid_o), 64'd0);
        checkOutput("wrap err", 64'(err_o), 64'd0);

        // Dual writes to distinct TIDs, then same-TID collision (hit wins)
        resetDut();
        applyStimulus(1'b1, 6'd0, 64'h50, 1'b1, 6'd1, 64'h51);
        step();
        applyStimulus(1'b1, 6'd2, 64'h52, 1'b1, 6'd3, 64'h53);
        step();
        applyStimulus(1'b0, '0, '0, 1'b1, 6'd4, 64'h54);
        checkOutput("coll pre err c2", 64'(err_o), 64'd0);
        step();
        applyStimulus(1'b1, 6'd5, 64'hC5, 1'b1, 6'd5, 64'hD5);
        checkOutput("coll pre err c3", 64'(err_o), 64'd0);
        step();
        applyStimulus(1'b1, 6'd5, 64'hEE, 1'b0, '0, '0);
        checkOutput("coll err set", 64'(err_o), 64'd1);
        step();
        idle();
        ready_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            expectResp($sformatf("coll rid%0d", i), tid_t'(i), (i == 5) ? 64'hC5 : 64'h50 + 64'(i));
            step();
        end
        checkOutput("coll end valid", 64'(valid_o), 64'd0);
        checkOutput("coll err sticky", 64'(err_o), 64'd1);

        // Synchronous reset in the middle of traffic
        resetDut();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, tid_t'(i), 64'h60 + 64'(i), 1'b0, '0, '0);
            step();
        end
        applyStimulus(1'b1, 6'd1, 64'h99, 1'b0, '0, '0);
        expectResp("midrst pre", 6'd0, 64'h60);
        step();
        idle();
        checkOutput("midrst err before", 64'(err_o), 64'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checkOutput("midrst valid", 64'(valid_o), 64'd0);
        checkOutput("midrst fullHit", 64'(full_hit_o), 64'd0);
        checkOutput("midrst fullMiss", 64'(full_miss_o), 64'd0);
        checkOutput("midrst err", 64'(err_o), 64'd0);
        ready_i = 1'b1;
        applyStimulus(1'b1, 6'd0, 64'hF0, 1'b0, '0, '0);
        step();
        idle();
        checkOutput("midrst c1 valid", 64'(valid_o), 64'd0);
        step();
        expectResp("midrst new", 6'd0, 64'hF0);
        step();
        checkOutput("midrst discarded", 64'(valid_o), 64'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
